// File: rtl/onehot_walker_pkg.sv
// rtl/onehot_walker_pkg.sv - shared state encoding and bit-decode helpers for the one-hot walker.
package onehot_walker_pkg;

  localparam int MinWidth = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } walker_state_e;

  // Per-bit decoders: bit idx of a width-bit pattern for position pos.
  function automatic logic nth_bit(input int pos, input int idx, input int width);
    return (idx < width) && (idx == pos);
  endfunction

  function automatic logic therm_upto(input int pos, input int idx, input int width);
    return (idx < width) && (idx <= pos);
  endfunction

endpackage

// File: rtl/onehot_walker_dec.sv
// rtl/onehot_walker_dec.sv - position to one-hot decoder gated by valid; ONEHOT_WALKER_THERM_EN adds thermometer output.
module onehot_walker_dec #(
  parameter int Width    = 32,
  parameter int PosWidth = 5
) (
  input  logic [PosWidth-1:0] pos_i,
  input  logic                valid_i,
`ifdef ONEHOT_WALKER_THERM_EN
  output logic [Width-1:0]    therm_o,
`endif
  output logic [Width-1:0]    onehot_o
);
  import onehot_walker_pkg::*;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    assign onehot_o[i] = valid_i & nth_bit(int'(pos_i), i, Width);
`ifdef ONEHOT_WALKER_THERM_EN
    assign therm_o[i]  = valid_i & therm_upto(int'(pos_i), i, Width);
`endif
  end

endmodule

// File: rtl/onehot_walker.sv
// rtl/onehot_walker.sv - streaming one-hot walker with rotate/saturate stride; ONEHOT_WALKER_THERM_EN adds therm_o.
module onehot_walker #(
  parameter int  Width     = 32,
  parameter int  StepWidth = 4,
  localparam int PosWidth  = ($clog2(Width) > 1) ? $clog2(Width) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_valid_i,
  input  logic [PosWidth-1:0]  load_pos_i,
  input  logic [StepWidth-1:0] stride_i,
  input  logic                 wrap_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [Width-1:0]     onehot_o,
`ifdef ONEHOT_WALKER_THERM_EN
  output logic [Width-1:0]     therm_o,
`endif
  output logic [PosWidth-1:0]  pos_o,
  output logic                 busy_o,
  output logic                 done_o
);
  import onehot_walker_pkg::*;

  if (Width < MinWidth) begin : g_bad_width
    $error("onehot_walker: Width must be at least 2");
  end
  if ((2 ** StepWidth) - 1 >= Width) begin : g_bad_step
    $error("onehot_walker: largest stride must be below Width");
  end

  localparam logic [PosWidth:0]   WidthExt = (PosWidth + 1)'(Width);
  localparam logic [PosWidth-1:0] LastPos  = PosWidth'(Width - 1);

  walker_state_e        r_state, w_state_nxt;
  logic [PosWidth-1:0]  r_pos, w_pos_nxt;
  logic [StepWidth-1:0] r_stride, w_stride_nxt;
  logic                 r_wrap, w_wrap_nxt;
  logic [PosWidth:0]    w_sum;
  logic [PosWidth-1:0]  w_pos_wrapped;
  logic [PosWidth-1:0]  w_load_pos;

  // One extra bit so overflow past Width is visible; stride < Width keeps one subtract enough.
  assign w_sum         = {1'b0, r_pos} + (PosWidth + 1)'(r_stride);
  assign w_pos_wrapped = (w_sum >= WidthExt) ? PosWidth'(w_sum - WidthExt) : w_sum[PosWidth-1:0];
  assign w_load_pos    = ({1'b0, load_pos_i} >= WidthExt) ? LastPos : load_pos_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_pos    <= '0;
      r_stride <= StepWidth'(1);
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos    <= w_pos_nxt;
      r_stride <= w_stride_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_stride_nxt = r_stride;
    w_wrap_nxt   = r_wrap;
    case (r_state)
      ST_IDLE: begin
        if (load_valid_i) begin
          w_pos_nxt = w_load_pos;
        end
        if (start_i && !stop_i) begin
          w_stride_nxt = (stride_i == '0) ? StepWidth'(1) : stride_i;
          w_wrap_nxt   = wrap_i;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          w_state_nxt = ST_IDLE;
        end else if (out_ready_i) begin
          if (r_wrap) begin
            w_pos_nxt = w_pos_wrapped;
          end else if (w_sum >= WidthExt) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_pos_nxt = w_sum[PosWidth-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_valid_o = (r_state == ST_RUN);
  assign busy_o      = (r_state == ST_RUN);
  assign done_o      = (r_state == ST_DONE);
  assign pos_o       = r_pos;

  onehot_walker_dec #(
    .Width    (Width),
    .PosWidth (PosWidth)
  ) u_dec (
    .pos_i    (r_pos),
    .valid_i  (out_valid_o),
`ifdef ONEHOT_WALKER_THERM_EN
    .therm_o  (therm_o),
`endif
    .onehot_o (onehot_o)
  );

endmodule

// File: tb/tb_onehot_walker.sv
// tb/tb_onehot_walker.sv - bench for onehot_walker at Width 32 and Width 5 against a per-cycle behavioural model.
module tb_onehot_walker;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_ld, a_wr, a_sta, a_sto, a_rdy, a_val, a_busy, a_done;
  logic [4:0]  a_lp, a_pos;
  logic [3:0]  a_st;
  logic [31:0] a_oh, a_th;

  logic        b_ld, b_wr, b_sta, b_sto, b_rdy, b_val, b_busy, b_done;
  logic [2:0]  b_lp, b_pos;
  logic [1:0]  b_st;
  logic [4:0]  b_oh, b_th;

`ifndef ONEHOT_WALKER_THERM_EN
  assign a_th = '0;
  assign b_th = '0;
`endif

  onehot_walker #(.Width(32), .StepWidth(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .load_valid_i(a_ld), .load_pos_i(a_lp),
    .stride_i(a_st), .wrap_i(a_wr), .start_i(a_sta), .stop_i(a_sto),
    .out_valid_o(a_val), .out_ready_i(a_rdy), .onehot_o(a_oh),
`ifdef ONEHOT_WALKER_THERM_EN
    .therm_o(a_th),
`endif
    .pos_o(a_pos), .busy_o(a_busy), .done_o(a_done)
  );

  onehot_walker #(.Width(5), .StepWidth(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .load_valid_i(b_ld), .load_pos_i(b_lp),
    .stride_i(b_st), .wrap_i(b_wr), .start_i(b_sta), .stop_i(b_sto),
    .out_valid_o(b_val), .out_ready_i(b_rdy), .onehot_o(b_oh),
`ifdef ONEHOT_WALKER_THERM_EN
    .therm_o(b_th),
`endif
    .pos_o(b_pos), .busy_o(b_busy), .done_o(b_done)
  );

  int n_pass = 0;
  int n_checks = 0;
  int m_state[2];  // 0 idle, 1 streaming, 2 ran off the end
  int m_pos[2];
  int m_stride[2];
  int m_wrap[2];
  int done_cnt[2];
  int obs_a[$];
  int obs_b[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_pos[d] = 0; m_stride[d] = 1; m_wrap[d] = 0;
    end
  endfunction

  function automatic void model_step(input int d, input int width, input bit ld, input int lp,
                                     input int st, input bit wr, input bit sta, input bit sto,
                                     input bit rdy);
    int nx;
    case (m_state[d])
      0: begin
        if (ld) m_pos[d] = (lp > width - 1) ? width - 1 : lp;
        if (sta && !sto) begin
          m_stride[d] = (st == 0) ? 1 : st;
          m_wrap[d]   = wr;
          m_state[d]  = 1;
        end
      end
      1: begin
        if (sto) m_state[d] = 0;
        else if (rdy) begin
          nx = m_pos[d] + m_stride[d];
          if (m_wrap[d] != 0) m_pos[d] = nx % width;
          else if (nx >= width) m_state[d] = 2;
          else m_pos[d] = nx;
        end
      end
      default: m_state[d] = 0;
    endcase
  endfunction

  function automatic logic [63:0] exp_oh(input int d);
    return (m_state[d] == 1) ? (64'd1 << m_pos[d]) : 64'd0;
  endfunction

  function automatic logic [63:0] exp_th(input int d);
    return (m_state[d] == 1) ? ((64'd1 << (m_pos[d] + 1)) - 64'd1) : 64'd0;
  endfunction

  task automatic compare_all();
    check("a.valid", 64'(a_val), 64'(m_state[0] == 1));
    check("a.busy", 64'(a_busy), 64'(m_state[0] == 1));
    check("a.done", 64'(a_done), 64'(m_state[0] == 2));
    check("a.pos", 64'(a_pos), 64'(m_pos[0]));
    check("a.onehot", 64'(a_oh), exp_oh(0));
    check("b.valid", 64'(b_val), 64'(m_state[1] == 1));
    check("b.done", 64'(b_done), 64'(m_state[1] == 2));
    check("b.pos", 64'(b_pos), 64'(m_pos[1]));
    check("b.onehot", 64'(b_oh), exp_oh(1));
`ifdef ONEHOT_WALKER_THERM_EN
    check("a.therm", 64'(a_th), exp_th(0));
    check("b.therm", 64'(b_th), exp_th(1));
`endif
  endtask

  task automatic tick();
    logic        hold_a, hold_b;
    logic [31:0] held_a;
    logic [4:0]  held_b;
    hold_a = a_val & ~a_rdy & ~a_sto; held_a = a_oh;
    hold_b = b_val & ~b_rdy & ~b_sto; held_b = b_oh;
    if (a_val && a_rdy && !a_sto) obs_a.push_back(int'(a_pos));
    if (b_val && b_rdy && !b_sto) obs_b.push_back(int'(b_pos));
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0, 32, a_ld, int'(a_lp), int'(a_st), a_wr, a_sta, a_sto, a_rdy);
      model_step(1, 5, b_ld, int'(b_lp), int'(b_st), b_wr, b_sta, b_sto, b_rdy);
    end
    #1;
    compare_all();
    if (a_done) done_cnt[0]++;
    if (b_done) done_cnt[1]++;
    if (hold_a && a_val) check("a.hold", 64'(a_oh), 64'(held_a));
    if (hold_b && b_val) check("b.hold", 64'(b_oh), 64'(held_b));
  endtask

  task automatic idle_inputs();
    a_ld = 0; a_lp = '0; a_st = '0; a_wr = 0; a_sta = 0; a_sto = 0; a_rdy = 0;
    b_ld = 0; b_lp = '0; b_st = '0; b_wr = 0; b_sta = 0; b_sto = 0; b_rdy = 0;
  endtask

  task automatic check_list(input string tag, input int got[$], input int exp[$]);
    check({tag, ".len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  initial begin
    int k;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    done_cnt[0] = 0; done_cnt[1] = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load and start together, stride 0 acts as 1.
    a_ld = 1; a_lp = 5; a_sta = 1; a_st = 0; a_wr = 0; a_rdy = 1;
    tick();
    a_ld = 0; a_sta = 0;
    check("t1.oh0", 64'(a_oh), 64'h20); tick();
    check("t1.oh1", 64'(a_oh), 64'h40); tick();
    check("t1.oh2", 64'(a_oh), 64'h80);
    a_sto = 1; tick(); a_sto = 0;
    check("t1.idle", 64'(a_val), 64'd0);

    // Rotate, stride 7 from 28.
    obs_a.delete(); done_cnt[0] = 0;
    a_ld = 1; a_lp = 28; a_st = 7; a_wr = 1; a_sta = 1; a_rdy = 1;
    tick();
    a_ld = 0; a_sta = 0;
    repeat (7) tick();
    a_sto = 1; tick(); a_sto = 0;
    check_list("t2.beats", obs_a, '{28, 3, 10, 17, 24, 31, 6});
    check("t2.no_done", 64'(done_cnt[0]), 64'd0);

    // Saturate, stride 4 from 20.
    obs_a.delete(); done_cnt[0] = 0;
    a_ld = 1; a_lp = 20; a_st = 4; a_wr = 0; a_sta = 1; a_rdy = 1;
    tick();
    a_ld = 0; a_sta = 0;
    k = 0;
    while (!a_done && k < 10) begin tick(); k++; end
    check("t3.done", 64'(a_done), 64'd1);
    check("t3.valid_low", 64'(a_val), 64'd0);
    check("t3.pos", 64'(a_pos), 64'd28);
    tick();
    check("t3.idle_done", 64'(a_done), 64'd0);
    check("t3.idle_busy", 64'(a_busy), 64'd0);
    check("t3.idle_pos", 64'(a_pos), 64'd28);
    check_list("t3.beats", obs_a, '{20, 24, 28});
    check("t3.done_cnt", 64'(done_cnt[0]), 64'd1);

    // Stop with ready at pos 9; a load in the same Run cycle is ignored.
    done_cnt[0] = 0;
    a_ld = 1; a_lp = 9; a_st = 3; a_wr = 1; a_sta = 1; a_rdy = 0;
    tick();
    a_ld = 0; a_sta = 0;
    tick();
    a_rdy = 1; a_sto = 1; a_ld = 1; a_lp = 2;
    tick();
    a_sto = 0; a_ld = 0;
    check("t4.pos", 64'(a_pos), 64'd9);
    check("t4.valid", 64'(a_val), 64'd0);
    tick();
    check("t4.pos_held", 64'(a_pos), 64'd9);
    check("t4.no_done", 64'(done_cnt[0]), 64'd0);

    // Width 5 rotate, stride 3 from 0.
    obs_b.delete();
    b_ld = 1; b_lp = 0; b_st = 3; b_wr = 1; b_sta = 1; b_rdy = 1;
    tick();
    b_ld = 0; b_sta = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef ONEHOT_WALKER_THERM_EN
      if (b_pos == 3'd3) check("t5.therm3", 64'(b_th), 64'h0F);
`endif
      tick();
    end
    b_sto = 1; tick(); b_sto = 0;
    check_list("t5.beats", obs_b, '{0, 3, 1, 4, 2, 0});

    // Random traffic on both instances, model checked every cycle.
    for (int i = 0; i < 400; i++) begin
      a_ld = ($urandom_range(0, 3) == 0); a_lp = 5'($urandom_range(0, 31));
      a_st = 4'($urandom_range(0, 15)); a_wr = 1'($urandom_range(0, 1));
      a_sta = ($urandom_range(0, 3) == 0); a_sto = ($urandom_range(0, 15) == 0);
      a_rdy = 1'($urandom_range(0, 1));
      b_ld = ($urandom_range(0, 3) == 0); b_lp = 3'($urandom_range(0, 7));
      b_st = 2'($urandom_range(0, 3)); b_wr = 1'($urandom_range(0, 1));
      b_sta = ($urandom_range(0, 3) == 0); b_sto = ($urandom_range(0, 15) == 0);
      b_rdy = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset mid-stream.
    idle_inputs();
    tick();
    a_ld = 1; a_lp = 3; a_st = 5; a_wr = 1; a_sta = 1; a_rdy = 1;
    tick();
    a_ld = 0; a_sta = 0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t7.valid", 64'(a_val), 64'd0);
    check("t7.onehot", 64'(a_oh), 64'd0);
    check("t7.busy", 64'(a_busy), 64'd0);
    check("t7.done", 64'(a_done), 64'd0);
    check("t7.pos", 64'(a_pos), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
